timer_run_ctrl: RTL and testbench
=================================

TIMER_RUN_CTRL -- requirements
Module: timer_run_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4, the number of consecutive stable synchronized samples needed to accept a button level change (legal range 2..255).
REQ-002 SHALL have parameter TICK_DIV, default 10, the clk cycles per count_en pulse while running (legal range 2..65535).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start_btn, input, 1 bit: raw asynchronous start button, active-high.
REQ-006 SHALL have port stop_btn, input, 1 bit: raw asynchronous stop/clear button, active-high.
REQ-007 SHALL have port mode_btn, input, 1 bit: raw asynchronous mode-toggle button, active-high.
REQ-008 SHALL have port run, output, 1 bit: high while in RUN.
REQ-009 SHALL have port count_en, output, 1 bit: one-cycle step strobe for the timer counter.
REQ-010 SHALL have port clear, output, 1 bit: one-cycle counter-clear strobe.
REQ-011 SHALL have port mode, output, 1 bit: count direction, 0 = up, 1 = down.
REQ-012 SHALL have port state, output, 2 bits: IDLE=00, RUN=01, PAUSE=10; 11 is never driven.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each debouncer SHALL update its level only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any intervening match SHALL restart the count at 0.
REQ-015 Each debouncer SHALL emit a registered one-cycle press event on a 0->1 debounced transition only; releases generate no event.
REQ-016 With raw input held stable, state SHALL change exactly DEB_CYCLES+3 clock edges after the first edge sampling the new raw level.
REQ-017 IDLE: start event -> RUN; stop event -> stay IDLE and pulse clear; mode event -> toggle mode.
REQ-018 RUN: stop event -> PAUSE; start and mode events ignored.
REQ-019 PAUSE: start event -> RUN; stop event -> IDLE and pulse clear; mode event ignored.
REQ-020 Simultaneous start and stop events SHALL be treated as stop only.
REQ-021 clear SHALL be high for exactly the one cycle after the transition (or IDLE self-loop) that caused it; consecutive stop events each produce one pulse.
REQ-022 Prescaler SHALL be a 16-bit counter 0..TICK_DIV-1: increments in RUN, holds in PAUSE, forced to 0 in IDLE.
REQ-023 count_en SHALL be high for one cycle when the prescaler equals TICK_DIV-1 in RUN, and the prescaler SHALL wrap to 0 on that same edge.
REQ-024 First count_en after IDLE->RUN SHALL occur on the TICK_DIV-th cycle in RUN; after PAUSE->RUN the remaining count SHALL resume without loss.
REQ-025 count_en SHALL never be high outside RUN; clear and count_en SHALL never be high in the same cycle.
REQ-026 run SHALL equal (state == RUN) combinationally from the state register.

Reset
REQ-027 While rst is high at a clock edge: state = IDLE, run = 0, count_en = 0, clear = 0, mode = 0, prescaler = 0, debounced levels = 0, debounce counters = 0, synchronizers = 0.
REQ-028 Reset SHALL override every event in the same cycle, including mid-RUN and mid-debounce; a button held through reset release SHALL be detected as a fresh press DEB_CYCLES+3 edges later.

Verification (DEB_CYCLES=4, TICK_DIV=10)
REQ-029 Start held high from edge 0 -> state=01 and run=1 at edge 7; first count_en high in the cycle after edge 16; period 10 thereafter.
REQ-030 start_btn glitch high 3 cycles, then low -> no event; state stays 00, all outputs 0.
REQ-031 RUN for 25 cycles, stop press, wait, start press -> state 01->10->01, no count_en in PAUSE, count_en interval across pause = 10 RUN cycles.
REQ-032 From PAUSE, stop press -> state=00, clear=1 for exactly 1 cycle, prescaler=0, count_en stays 0.
REQ-033 mode press in IDLE -> mode=1; mode press in RUN -> mode unchanged; start and stop pressed on the same edge in PAUSE -> IDLE with one clear pulse.
REQ-034 rst asserted mid-RUN with buttons held -> all outputs 0 next edge; after release, held start re-enters RUN at edge DEB_CYCLES+3 = 7.

Source files
------------

// File: rtl/timer_run_ctrl.sv
// Run/pause/clear controller for a stopwatch-style timer: three debounced push
// buttons drive an IDLE/RUN/PAUSE state machine and a prescaled count strobe.
module timer_run_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int TICK_DIV   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       mode_btn,
  output logic       run,
  output logic       count_en,
  output logic       clear,
  output logic       mode,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam int              BTN_START = 0;
  localparam int              BTN_STOP  = 1;
  localparam int              BTN_MODE  = 2;
  localparam logic [7:0]      DEB_LAST  = 8'(DEB_CYCLES - 1);
  localparam logic [15:0]     TICK_LAST = 16'(TICK_DIV - 1);

  state_t      state_q;
  logic [2:0]  raw;
  logic [2:0]  sync1;
  logic [2:0]  sync2;
  logic [2:0]  level;
  logic [2:0]  level_d;
  logic [2:0]  press;
  logic [7:0]  deb_cnt [3];
  logic [15:0] presc;

  assign raw = {mode_btn, stop_btn, start_btn};

  // Synchronizer, debouncer and press-edge detector for all three buttons.
  // The level updates on the DEB_CYCLES-th consecutive differing sample; a
  // matching sample in between restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      press   <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      // NOTE: every register here uses <= so all stages sample the values from
      // before this edge; blocking assignments would collapse the flop chain.
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != level[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            level[i]   <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 8'd1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Control FSM; stop always wins over a simultaneous start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      clear   <= 1'b0;
      mode    <= 1'b0;
      presc   <= '0;
    end else begin
      clear <= 1'b0;
      unique case (state_q)
        IDLE: begin
          presc <= '0;
          if (press[BTN_STOP]) begin
            clear <= 1'b1;
          end else if (press[BTN_START]) begin
            state_q <= RUN;
          end
          if (press[BTN_MODE]) mode <= ~mode;
        end
        RUN: begin
          presc <= (presc == TICK_LAST) ? '0 : presc + 16'd1;
          if (press[BTN_STOP]) state_q <= PAUSE;
        end
        PAUSE: begin
          if (press[BTN_STOP]) begin
            state_q <= IDLE;
            clear   <= 1'b1;
            presc   <= '0;
          end else if (press[BTN_START]) begin
            state_q <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign run      = (state_q == RUN);
  assign count_en = (state_q == RUN) && (presc == TICK_LAST);
  assign state    = state_q;

endmodule

// File: tb/tb_timer_run_ctrl.sv
// Directed self-checking bench for timer_run_ctrl with DEB_CYCLES=4, TICK_DIV=10.
module tb_timer_run_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn;
  logic       stop_btn;
  logic       mode_btn;
  logic       run;
  logic       count_en;
  logic       clear;
  logic       mode;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  timer_run_ctrl #(.DEB_CYCLES(4), .TICK_DIV(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_btn (start_btn),
    .stop_btn  (stop_btn),
    .mode_btn  (mode_btn),
    .run       (run),
    .count_en  (count_en),
    .clear     (clear),
    .mode      (mode),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic exp_mode);
    check({tag, "_state"}, state, 2'b00);
    check({tag, "_run"}, run, 1'b0);
    check({tag, "_count_en"}, count_en, 1'b0);
    check({tag, "_clear"}, clear, 1'b0);
    check({tag, "_mode"}, mode, exp_mode);
  endtask

  initial begin
    int ce_seen;

    rst = 1'b1; start_btn = 1'b0; stop_btn = 1'b0; mode_btn = 1'b0;
    step(3);
    check_idle_outputs("reset", 1'b0);
    rst = 1'b0;
    step(1);

    // Three-cycle glitch is one short of the debounce threshold.
    start_btn = 1'b1;
    step(3);
    start_btn = 1'b0;
    step(15);
    check_idle_outputs("glitch", 1'b0);

    // Start held from edge 0: RUN at edge 7, count_en after edges 16 and 26.
    start_btn = 1'b1;
    step(7);
    check("start_edge6_state", state, 2'b00);
    step(1);
    check("start_edge7_state", state, 2'b01);
    check("start_edge7_run", run, 1'b1);
    step(8);
    check("ce_edge15", count_en, 1'b0);
    step(1);
    check("ce_edge16", count_en, 1'b1);
    step(1);
    check("ce_edge17", count_en, 1'b0);
    step(8);
    check("ce_edge25", count_en, 1'b0);
    step(1);
    check("ce_edge26", count_en, 1'b1);

    // Pause right after a strobe: 7 RUN cycles elapse before PAUSE takes effect,
    // so 3 more RUN cycles after resuming complete the 10-cycle interval.
    start_btn = 1'b0;
    stop_btn  = 1'b1;
    step(7);
    check("pause_edge6_state", state, 2'b01);
    step(1);
    check("pause_state", state, 2'b10);
    check("pause_run", run, 1'b0);
    stop_btn = 1'b0;
    ce_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (count_en === 1'b1) ce_seen++;
    end
    check("pause_no_ce", ce_seen, 0);
    check("pause_hold_state", state, 2'b10);
    start_btn = 1'b1;
    step(8);
    check("resume_state", state, 2'b01);
    check("resume_ce_cycle1", count_en, 1'b0);
    step(1);
    check("resume_ce_cycle2", count_en, 1'b0);
    step(1);
    check("resume_ce_cycle3", count_en, 1'b1);
    step(1);
    check("resume_ce_cycle4", count_en, 1'b0);
    start_btn = 1'b0;
    step(10);

    // Mode press ignored while running.
    mode_btn = 1'b1;
    step(12);
    mode_btn = 1'b0;
    step(10);
    check("mode_in_run", mode, 1'b0);
    check("mode_in_run_state", state, 2'b01);

    // RUN -> PAUSE -> IDLE with a single clear pulse.
    stop_btn = 1'b1;
    step(8);
    check("run_to_pause", state, 2'b10);
    stop_btn = 1'b0;
    step(10);
    stop_btn = 1'b1;
    step(7);
    check("pause_stop_edge6_clear", clear, 1'b0);
    step(1);
    check("pause_to_idle_state", state, 2'b00);
    check("pause_to_idle_clear", clear, 1'b1);
    check("pause_to_idle_ce", count_en, 1'b0);
    step(1);
    check("clear_one_cycle", clear, 1'b0);
    stop_btn = 1'b0;
    step(10);

    // Stop in IDLE still pulses clear.
    stop_btn = 1'b1;
    step(8);
    check("idle_stop_clear", clear, 1'b1);
    check("idle_stop_state", state, 2'b00);
    step(1);
    check("idle_stop_clear_end", clear, 1'b0);
    stop_btn = 1'b0;
    step(10);

    // Mode press in IDLE toggles direction.
    mode_btn = 1'b1;
    step(7);
    check("mode_idle_edge6", mode, 1'b0);
    step(1);
    check("mode_idle_edge7", mode, 1'b1);
    mode_btn = 1'b0;
    step(10);

    // Prescaler was cleared on the way to IDLE: first strobe on the 10th RUN cycle.
    start_btn = 1'b1;
    step(8);
    check("restart_state", state, 2'b01);
    step(8);
    check("restart_ce_edge15", count_en, 1'b0);
    step(1);
    check("restart_ce_edge16", count_en, 1'b1);
    start_btn = 1'b0;
    step(10);
    stop_btn = 1'b1;
    step(8);
    check("restart_pause", state, 2'b10);
    stop_btn = 1'b0;
    step(10);

    // Simultaneous start and stop in PAUSE behaves as stop only.
    start_btn = 1'b1;
    stop_btn  = 1'b1;
    step(8);
    check("both_state", state, 2'b00);
    check("both_clear", clear, 1'b1);
    step(1);
    check("both_clear_end", clear, 1'b0);
    start_btn = 1'b0;
    stop_btn  = 1'b0;
    step(10);
    check("both_settled_state", state, 2'b00);
    check("both_mode_kept", mode, 1'b1);

    // Reset mid-RUN with start held, then fresh press after release.
    start_btn = 1'b1;
    step(8);
    check("pre_reset_run", state, 2'b01);
    step(5);
    rst = 1'b1;
    step(1);
    check_idle_outputs("mid_run_reset", 1'b0);
    step(2);
    rst = 1'b0;
    step(7);
    check("post_reset_edge6", state, 2'b00);
    step(1);
    check("post_reset_edge7_state", state, 2'b01);
    check("post_reset_edge7_run", run, 1'b1);
    start_btn = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
